// File: rtl/ram_2_port_be.sv
// Simple dual-port table RAM: byte-lane writes, 1- or 2-cycle registered reads,
// optional write-to-read bypass and a zeroing sweep that runs after every reset.
module ram_2_port_be #(
   parameter int WORD_SIZE     = 16,
   parameter int BYTE_SIZE     = 8,
   parameter int ADDR_SIZE     = 5,
   parameter int NUM_WORDS     = 2**5,
   parameter int RD_LATENCY    = 1,
   parameter int BYPASS        = 1,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [ADDR_SIZE-1:0]             wr_addr,
   input  logic [WORD_SIZE/BYTE_SIZE-1:0]   wr_byte_en,
   input  logic [WORD_SIZE-1:0]             wr_word,
   input  logic                             rd_en,
   input  logic [ADDR_SIZE-1:0]             rd_addr,
   output logic [WORD_SIZE-1:0]             rd_word,
   output logic                             rd_valid,
   output logic                             init_busy
);

   localparam int LANES  = WORD_SIZE / BYTE_SIZE;
   localparam int MEM_AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t                r_state;
   logic [MEM_AW-1:0]     r_cnt;
   logic                  r_init_busy;
   logic [WORD_SIZE-1:0]  r_mem [NUM_WORDS];

   logic                  r_vld_p0;
   logic [WORD_SIZE-1:0]  r_data_p0;

   logic                  w_ready;
   logic                  w_wr_in;
   logic                  w_rd_in;
   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic [MEM_AW-1:0]     w_wr_idx;
   logic [MEM_AW-1:0]     w_rd_idx;
   logic [WORD_SIZE-1:0]  w_old;
   logic [WORD_SIZE-1:0]  w_rd_data;

   function automatic logic [WORD_SIZE-1:0] f_merge(
      input logic [WORD_SIZE-1:0] old_w,
      input logic [WORD_SIZE-1:0] new_w,
      input logic [LANES-1:0]     be
   );
      logic [WORD_SIZE-1:0] m;
      m = old_w;
      for (int i = 0; i < LANES; i++)
         if (be[i]) m[i*BYTE_SIZE +: BYTE_SIZE] = new_w[i*BYTE_SIZE +: BYTE_SIZE];
      return m;
   endfunction

   assign w_ready  = (r_state == S_READY) && !rst;
   assign w_wr_in  = (32'(wr_addr) < 32'(NUM_WORDS));
   assign w_rd_in  = (32'(rd_addr) < 32'(NUM_WORDS));
   assign w_wr_ok  = w_ready && wr_en && w_wr_in;
   assign w_rd_ok  = w_ready && rd_en;
   assign w_wr_idx = wr_addr[MEM_AW-1:0];
   assign w_rd_idx = rd_addr[MEM_AW-1:0];
   assign w_old    = w_rd_in ? r_mem[w_rd_idx] : '0;

   // Same-cycle hit on the written address sees the merged word when bypass is on
   always_comb begin
      w_rd_data = w_old;
      if ((BYPASS != 0) && w_wr_ok && w_rd_in && (wr_addr == rd_addr))
         w_rd_data = f_merge(w_old, wr_word, wr_byte_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= (INIT_ON_RESET != 0) ? S_INIT : S_READY;
         r_init_busy <= (INIT_ON_RESET != 0);
         r_cnt       <= '0;
      end else if (r_state == S_INIT) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == MEM_AW'(NUM_WORDS - 1)) begin
            r_state     <= S_READY;
            r_init_busy <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_INIT && !rst)
         r_mem[r_cnt] <= '0;
      else if (w_wr_ok)
         r_mem[w_wr_idx] <= f_merge(r_mem[w_wr_idx], wr_word, wr_byte_en);
   end

   // Stage p0: array read registered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p0  <= 1'b0;
         r_data_p0 <= '0;
      end else begin
         r_vld_p0 <= w_rd_ok;
         if (w_rd_ok) r_data_p0 <= w_rd_data;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                 r_vld_p1;
         logic [WORD_SIZE-1:0] r_data_p1;

         // Stage p1: extra output register
         always_ff @(posedge clk) begin
            if (rst) begin
               r_vld_p1  <= 1'b0;
               r_data_p1 <= '0;
            end else begin
               r_vld_p1 <= r_vld_p0;
               if (r_vld_p0) r_data_p1 <= r_data_p0;
            end
         end

         assign rd_word  = r_data_p1;
         assign rd_valid = r_vld_p1;
      end else begin : g_lat1
         assign rd_word  = r_data_p0;
         assign rd_valid = r_vld_p0;
      end
   endgenerate

   assign init_busy = r_init_busy;

endmodule

// File: tb/tb_ram_2_port_be.sv
// Bench for ram_2_port_be: two instances (32 words/latency 1/bypass vs 24 words/latency 2/no bypass)
// share the stimulus; a per-instance reference model schedules each read result by edge number.
module tb_ram_2_port_be;
   localparam int W  = 16;
   localparam int AW = 5;
   localparam int NE = 2048;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, rd_en;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [1:0]    wr_byte_en;
   logic [W-1:0]  wr_word;
   logic [W-1:0]  rd_word_a, rd_word_b;
   logic          rd_valid_a, rd_valid_b, init_busy_a, init_busy_b;

   always #5 clk = ~clk;

   ram_2_port_be #(.WORD_SIZE(16), .BYTE_SIZE(8), .ADDR_SIZE(5), .NUM_WORDS(32),
                   .RD_LATENCY(1), .BYPASS(1), .INIT_ON_RESET(1)) u_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_byte_en(wr_byte_en),
      .wr_word(wr_word), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word_a),
      .rd_valid(rd_valid_a), .init_busy(init_busy_a));

   ram_2_port_be #(.WORD_SIZE(16), .BYTE_SIZE(8), .ADDR_SIZE(5), .NUM_WORDS(24),
                   .RD_LATENCY(2), .BYPASS(0), .INIT_ON_RESET(1)) u_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_byte_en(wr_byte_en),
      .wr_word(wr_word), .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word_b),
      .rd_valid(rd_valid_b), .init_busy(init_busy_b));

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
   endtask

   // Reference model: memory contents, remaining sweep cycles, results due per edge
   int           m_lat [2];
   int           m_nw  [2];
   bit           m_byp [2];
   logic [W-1:0] m_mem [2][32];
   int           m_busy[2];
   logic [W-1:0] m_last[2];
   bit           s_vld [2][NE];
   logic [W-1:0] s_dat [2][NE];
   int           ecnt = 0;

   function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                          input logic [1:0] be);
      logic [W-1:0] r;
      r = o;
      if (be[0]) r[7:0]  = n[7:0];
      if (be[1]) r[15:8] = n[15:8];
      return r;
   endfunction

   task automatic model_edge();
      logic [W-1:0] d;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_busy[k] = m_nw[k];
            m_last[k] = '0;
            s_vld[k][ecnt]   = 1'b0;
            s_vld[k][ecnt+1] = 1'b0;
            for (int a = 0; a < 32; a++) m_mem[k][a] = '0;
         end else if (m_busy[k] > 0) begin
            m_busy[k]--;
         end else begin
            if (rd_en) begin
               d = (int'(rd_addr) < m_nw[k]) ? m_mem[k][rd_addr] : '0;
               if (m_byp[k] && wr_en && wr_addr == rd_addr && int'(rd_addr) < m_nw[k])
                  d = merge(d, wr_word, wr_byte_en);
               s_vld[k][ecnt + m_lat[k] - 1] = 1'b1;
               s_dat[k][ecnt + m_lat[k] - 1] = d;
            end
            if (wr_en && int'(wr_addr) < m_nw[k])
               m_mem[k][wr_addr] = merge(m_mem[k][wr_addr], wr_word, wr_byte_en);
         end
         if (s_vld[k][ecnt]) m_last[k] = s_dat[k][ecnt];
      end
   endtask

   task automatic step(input bit we, input logic [AW-1:0] wa, input logic [1:0] be,
                       input logic [W-1:0] wd, input bit re, input logic [AW-1:0] ra);
      wr_en = we; wr_addr = wa; wr_byte_en = be; wr_word = wd; rd_en = re; rd_addr = ra;
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("vld_a@%0d", ecnt),  16'(rd_valid_a),  16'(s_vld[0][ecnt]));
      chk($sformatf("word_a@%0d", ecnt), rd_word_a,        m_last[0]);
      chk($sformatf("busy_a@%0d", ecnt), 16'(init_busy_a), 16'(m_busy[0] > 0));
      chk($sformatf("vld_b@%0d", ecnt),  16'(rd_valid_b),  16'(s_vld[1][ecnt]));
      chk($sformatf("word_b@%0d", ecnt), rd_word_b,        m_last[1]);
      chk($sformatf("busy_b@%0d", ecnt), 16'(init_busy_b), 16'(m_busy[1] > 0));
      if (ecnt < NE - 4) ecnt++;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 2'b00, 16'h0, 1'b0, 5'd0);
   endtask

   // Counts cycles after rst falls until each instance drops init_busy
   task automatic sweep_count(input string tag);
      int n = 0, na = 0, nb = 0;
      while ((init_busy_a || init_busy_b) && n < 100) begin
         idle();
         n++;
         if (!init_busy_a && na == 0) na = n;
         if (!init_busy_b && nb == 0) nb = n;
      end
      chk({tag, "_sweep_a"}, 16'(na), 16'd32);
      chk({tag, "_sweep_b"}, 16'(nb), 16'd24);
   endtask

   typedef struct {
      bit           we;
      logic [AW-1:0] wa;
      logic [1:0]   be;
      logic [W-1:0] wd;
      bit           re;
      logic [AW-1:0] ra;
      bit           va;
      logic [W-1:0] da;
      bit           vb;
      logic [W-1:0] db;
   } vec_t;

   vec_t tbl[13];
   bit   ev[6];

   initial begin
      m_lat[0] = 1; m_nw[0] = 32; m_byp[0] = 1'b1;
      m_lat[1] = 2; m_nw[1] = 24; m_byp[1] = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int e = 0; e < NE; e++) begin s_vld[k][e] = 1'b0; s_dat[k][e] = '0; end

      //            we    wa     be     wd        re    ra     va    da        vb    db
      tbl[0]  = '{1'b1, 5'd23, 2'b11, 16'h5A5A, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[1]  = '{1'b1, 5'd3,  2'b11, 16'hABCD, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[2]  = '{1'b1, 5'd3,  2'b01, 16'h1234, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0, 16'h0000};
      tbl[3]  = '{1'b0, 5'd0,  2'b00, 16'h0000, 1'b1, 5'd3,  1'b1, 16'hAB34, 1'b0, 16'h0000};
      tbl[4]  = '{1'b1, 5'd5,  2'b11, 16'h1111, 1'b0, 5'd0,  1'b0, 16'hAB34, 1'b1, 16'hAB34};
      tbl[5]  = '{1'b1, 5'd5,  2'b10, 16'h2222, 1'b1, 5'd5,  1'b1, 16'h2211, 1'b0, 16'hAB34};
      tbl[6]  = '{1'b0, 5'd0,  2'b00, 16'h0000, 1'b1, 5'd5,  1'b1, 16'h2211, 1'b1, 16'h1111};
      tbl[7]  = '{1'b1, 5'd30, 2'b11, 16'hFFFF, 1'b0, 5'd0,  1'b0, 16'h2211, 1'b1, 16'h2211};
      tbl[8]  = '{1'b0, 5'd0,  2'b00, 16'h0000, 1'b1, 5'd30, 1'b1, 16'hFFFF, 1'b0, 16'h2211};
      tbl[9]  = '{1'b1, 5'd5,  2'b00, 16'h0000, 1'b1, 5'd5,  1'b1, 16'h2211, 1'b1, 16'h0000};
      tbl[10] = '{1'b0, 5'd0,  2'b00, 16'h0000, 1'b1, 5'd23, 1'b1, 16'h5A5A, 1'b1, 16'h2211};
      tbl[11] = '{1'b0, 5'd0,  2'b00, 16'h0000, 1'b0, 5'd0,  1'b0, 16'h5A5A, 1'b1, 16'h5A5A};
      tbl[12] = '{1'b0, 5'd0,  2'b00, 16'h0000, 1'b0, 5'd0,  1'b0, 16'h5A5A, 1'b0, 16'h5A5A};

      rst = 1'b1;
      for (int i = 0; i < 3; i++) idle();
      chk("rst_word_a", rd_word_a, 16'h0000);
      chk("rst_busy_b", 16'(init_busy_b), 16'h0001);
      rst = 1'b0;
      sweep_count("init");

      for (int a = 0; a < 32; a++) step(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'(a));
      idle();
      idle();

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].we, tbl[i].wa, tbl[i].be, tbl[i].wd, tbl[i].re, tbl[i].ra);
         chk($sformatf("tbl%0d_vld_a", i),  16'(rd_valid_a), 16'(tbl[i].va));
         chk($sformatf("tbl%0d_word_a", i), rd_word_a,       tbl[i].da);
         chk($sformatf("tbl%0d_vld_b", i),  16'(rd_valid_b), 16'(tbl[i].vb));
         chk($sformatf("tbl%0d_word_b", i), rd_word_b,       tbl[i].db);
      end

      // Back-to-back reads through the two-stage instance
      for (int a = 0; a < 4; a++) step(1'b1, 5'(a), 2'b11, 16'(a), 1'b0, 5'd0);
      ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 6; k++) begin
         if (k < 4) step(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'(k));
         else       idle();
         chk($sformatf("burst%0d_vld_b", k), 16'(rd_valid_b), 16'(ev[k]));
         if (ev[k]) chk($sformatf("burst%0d_word_b", k), rd_word_b, 16'(k - 1));
      end

      // A read in flight when rst arrives is dropped; reset mid-sweep restarts it
      step(1'b1, 5'd7, 2'b11, 16'h7777, 1'b0, 5'd0);
      step(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd7);
      rst = 1'b1;
      step(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd7);
      chk("pending_lost_b", 16'(rd_valid_b), 16'h0000);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd7);
      rst = 1'b1;
      step(1'b0, 5'd0, 2'b00, 16'h0, 1'b1, 5'd3);
      rst = 1'b0;
      sweep_count("restart");

      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] wa, ra;
         wa = 5'($urandom_range(0, 31));
         ra = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) ra = wa;
         step(1'($urandom_range(0, 1)), wa, 2'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), ra);
      end
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
